// File: rtl/prll_rr_bus_arbiter.sv
// Shared-bus round-robin arbiter: N FWFT source FIFOs, one packet at a time, routed by dest-ID or broadcast.
// Latency: pndng sampled at edge t -> pop in cycle t+1 -> push in cycle t+2 when unblocked; 1 packet / 3 cycles peak.
// Backpressure: holds the packet while any target is full (all-or-nothing); drops after TIMEOUT wait cycles.
module prll_rr_bus_arbiter #(
    parameter int                  DRVRS     = 9,
    parameter int                  BITS      = 32,
    parameter int                  ID_BITS   = 8,
    parameter logic [ID_BITS-1:0]  BROADCAST = {ID_BITS{1'b1}},
    parameter int                  TIMEOUT   = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DRVRS-1:0]        pndng_i,
    input  logic [DRVRS*BITS-1:0]   d_pop_i,
    output logic [DRVRS-1:0]        pop_o,
    input  logic [DRVRS-1:0]        full_i,
    output logic [DRVRS-1:0]        push_o,
    output logic [BITS-1:0]         d_push_o,
    output logic                    busy_o,
    output logic                    drop_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int PTR_W  = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DELIVER} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DRVRS-1:0]    gnt_q, win_oh_d;
    logic [DRVRS-1:0]    mask_q, mask_d;
    logic [DRVRS-1:0]    pop_q, push_q;
    logic [BITS-1:0]     pkt_q, head_d;
    logic                drop_q;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [WCNT_W-1:0]   wait_cnt_q;
    logic                found;
    logic [PTR_W:0]      sum;
    logic [ID_BITS-1:0]  dest_id;
    logic [DRVRS-1:0]    dest_oh;

    // Round-robin search: first pending driver at or after rr_ptr, wrapping at DRVRS-1.
    always_comb begin
        win_oh_d = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        sum      = '0;
        for (int k = 0; k < DRVRS; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(DRVRS)) begin
                sum = sum - (PTR_W+1)'(DRVRS);
            end
            if (!found && pndng_i[sum[PTR_W-1:0]]) begin
                found                     = 1'b1;
                win_oh_d[sum[PTR_W-1:0]]  = 1'b1;
                rr_ptr_d = (sum[PTR_W-1:0] == PTR_W'(DRVRS - 1)) ? '0
                                                                 : sum[PTR_W-1:0] + PTR_W'(1);
            end
        end
    end

    // Select the granted head word and decode its destination mask; an empty mask means invalid.
    always_comb begin
        head_d = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (gnt_q[i]) begin
                head_d = d_pop_i[i*BITS +: BITS];
            end
        end
        dest_id = head_d[BITS-1 -: ID_BITS];
        dest_oh = '0;
        for (int i = 0; i < DRVRS; i++) begin
            dest_oh[i] = (32'(dest_id) == 32'(i));
        end
        // Self-addressed packets fall out as an empty mask, same as out-of-range IDs.
        mask_d = (dest_id == BROADCAST) ? ~gnt_q : (dest_oh & ~gnt_q);
    end

    assign drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;

    // Arbitration FSM with registered strobes; pop/push/drop default low so each lasts one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            mask_q     <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            pkt_q      <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            pop_q  <= '0;
            push_q <= '0;
            drop_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|pndng_i) begin
                        state_q  <= S_GRANT;
                        gnt_q    <= win_oh_d;
                        pop_q    <= win_oh_d;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                S_GRANT: begin
                    state_q    <= S_DELIVER;
                    pkt_q      <= head_d;
                    mask_q     <= mask_d;
                    wait_cnt_q <= '0;
                    if (mask_d == '0) begin
                        drop_q     <= 1'b1;
                        drop_cnt_q <= drop_cnt_d;
                    end else if ((mask_d & full_i) == '0) begin
                        push_q <= mask_d;
                    end
                end
                S_DELIVER: begin
                    if (push_q != '0 || drop_q) begin
                        state_q <= S_IDLE;
                    end else if ((mask_q & full_i) == '0) begin
                        push_q <= mask_q;
                    end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
                        wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
                        drop_q     <= 1'b1;
                        drop_cnt_q <= drop_cnt_d;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pop_o      = pop_q;
    assign push_o     = push_q;
    assign d_push_o   = pkt_q;
    assign busy_o     = (state_q != S_IDLE);
    assign drop_o     = drop_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_prll_rr_bus_arbiter.sv
// Scoreboard bench for prll_rr_bus_arbiter: FWFT source model, expected pop/push/drop queues, negedge monitor.
// Directed scenarios: single, round-robin, broadcast, backpressure, timeout/invalid, reset mid-packet.
// Every wait is cycle-bounded; a global watchdog ends the run if the DUT stalls.
module tb_prll_rr_bus_arbiter;

    typedef struct {
        logic        is_drop;
        logic [8:0]  mask;
        logic [31:0] data;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [8:0]    pndng_i;
    logic [287:0]  d_pop_i;
    logic [8:0]    pop_o;
    logic [8:0]    full_i;
    logic [8:0]    push_o;
    logic [31:0]   d_push_o;
    logic          busy_o;
    logic          drop_o;
    logic [15:0]   drop_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] src_mem [9][8] = '{default: '0};
    logic [7:0]  wr_p [9]       = '{default: 8'd0};
    logic [7:0]  rd_p [9]       = '{default: 8'd0};

    exp_t        exp_q[$];
    logic [8:0]  exp_pop[$];
    logic        rr_chk = 1'b0;
    int          last_pop_cyc = -1;

    prll_rr_bus_arbiter dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .pndng_i    (pndng_i),
        .d_pop_i    (d_pop_i),
        .pop_o      (pop_o),
        .full_i     (full_i),
        .push_o     (push_o),
        .d_push_o   (d_push_o),
        .busy_o     (busy_o),
        .drop_o     (drop_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FWFT source FIFOs: pending while the driver's queue is non-empty, head word on its slice.
    always_comb begin
        pndng_i = '0;
        d_pop_i = '0;
        for (int i = 0; i < 9; i++) begin
            pndng_i[i]          = (rd_p[i] != wr_p[i]);
            d_pop_i[i*32 +: 32] = src_mem[i][rd_p[i][2:0]];
        end
    end

    // Retire the popped head just after the edge that ends the grant cycle.
    always @(negedge clk_i) begin
        logic [8:0] pop_seen;
        if (pop_o != '0) begin
            pop_seen = pop_o;
            @(posedge clk_i);
            #1;
            for (int i = 0; i < 9; i++) begin
                if (pop_seen[i]) rd_p[i] = rd_p[i] + 8'd1;
            end
        end
    end

    // Monitor: every pop/push/drop the DUT presents is matched against the expected queues.
    always @(negedge clk_i) begin
        exp_t       e;
        logic [8:0] ep;
        if (rst_ni === 1'b1) begin
            if (pop_o != '0) begin
                if (exp_pop.size() == 0) begin
                    chk("pop_unexpected", 32'(pop_o), 32'h0);
                end else begin
                    ep = exp_pop.pop_front();
                    chk("pop_order", 32'(pop_o), 32'(ep));
                end
                if (rr_chk && last_pop_cyc >= 0) chk("pop_spacing", 32'(cyc - last_pop_cyc), 32'd3);
                last_pop_cyc = cyc;
            end
            if (pop_o != '0 || push_o != '0) begin
                chk("pop_push_exclusive", {31'd0, (pop_o != '0) && (push_o != '0)}, 32'd0);
            end
            if (push_o != '0 || drop_o) begin
                if (exp_q.size() == 0) begin
                    chk("event_unexpected", {22'd0, drop_o, push_o}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_drop", 32'(drop_o), 32'(e.is_drop));
                    chk("event_mask", 32'(push_o), 32'(e.mask));
                    if (!e.is_drop) chk("event_data", d_push_o, e.data);
                end
            end
        end
    end

    task automatic send(input int d, input logic [31:0] data);
        src_mem[d][wr_p[d][2:0]] = data;
        wr_p[d] = wr_p[d] + 8'd1;
    endtask

    task automatic expect_push(input int src, input logic [8:0] mask, input logic [31:0] data);
        exp_pop.push_back(9'd1 << src);
        exp_q.push_back('{is_drop: 1'b0, mask: mask, data: data});
    endtask

    task automatic expect_drop(input int src);
        exp_pop.push_back(9'd1 << src);
        exp_q.push_back('{is_drop: 1'b1, mask: 9'h0, data: 32'h0});
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_pop.size() != 0 || busy_o) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= budget) begin
            chk(name, 32'(exp_q.size() + exp_pop.size()), 32'd0);
            exp_q.delete();
            exp_pop.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          d;
        int          hold_bad;
        full_i = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_pop", 32'(pop_o), 32'h0);
        chk("rst_push", 32'(push_o), 32'h0);
        chk("rst_d_push", d_push_o, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_drop", 32'(drop_o), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt_o), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // T1: single packet, check exact latency.
        send(0, 32'h03AB_CDEF);
        expect_push(0, 9'h008, 32'h03AB_CDEF);
        @(negedge clk_i);
        chk("t1_pop_t1", 32'(pop_o), 32'h001);
        @(negedge clk_i);
        chk("t1_push_t2", 32'(push_o), 32'h008);
        chk("t1_data_t2", d_push_o, 32'h03AB_CDEF);
        @(negedge clk_i);
        chk("t1_busy_t3", 32'(busy_o), 32'h0);
        chk("t1_d_push_held", d_push_o, 32'h03AB_CDEF);
        wait_quiet("t1_timeout", 20);

        // T2: all drivers pending with two packets each; pointer sits at 1 after T1.
        rr_chk       = 1'b1;
        last_pop_cyc = -1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) begin
                send(i, {8'((i + 1) % 9), 8'h5A, 8'(i), 8'(k)});
            end
        end
        for (int n = 0; n < 18; n++) begin
            d = (1 + n) % 9;
            w = {8'((d + 1) % 9), 8'h5A, 8'(d), 8'(n / 9)};
            expect_push(d, 9'd1 << ((d + 1) % 9), w);
        end
        wait_quiet("t2_timeout", 100);
        rr_chk = 1'b0;

        // T3: broadcast from driver 4 reaches everyone except driver 4.
        @(negedge clk_i);
        send(4, 32'hFF00_0001);
        expect_push(4, 9'h1EF, 32'hFF00_0001);
        wait_quiet("t3_timeout", 20);

        // T4: target held full for 10 cycles; push one cycle after release, no drop.
        @(negedge clk_i);
        full_i = 9'h020;
        send(2, 32'h0500_0002);
        expect_push(2, 9'h020, 32'h0500_0002);
        hold_bad = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (push_o != '0) hold_bad++;
        end
        chk("t4_no_push_while_full", 32'(hold_bad), 32'd0);
        full_i = '0;
        @(negedge clk_i);
        chk("t4_push_after_release", 32'(push_o), 32'h020);
        wait_quiet("t4_timeout", 20);
        chk("t4_no_drop", 32'(drop_cnt_o), 32'd0);

        // T5: stuck-full target times out; then out-of-range and self-addressed IDs drop.
        @(negedge clk_i);
        full_i = 9'h020;
        send(6, 32'h0500_0006);
        expect_drop(6);
        wait_quiet("t5_timeout_wait", 120);
        chk("t5_drop_cnt_1", 32'(drop_cnt_o), 32'd1);
        full_i = '0;
        @(negedge clk_i);
        send(7, 32'h2000_0007);
        expect_drop(7);
        wait_quiet("t5_invalid_wait", 20);
        chk("t5_drop_cnt_2", 32'(drop_cnt_o), 32'd2);
        @(negedge clk_i);
        send(8, 32'h0800_0008);
        expect_drop(8);
        wait_quiet("t5_self_wait", 20);
        chk("t5_drop_cnt_3", 32'(drop_cnt_o), 32'd3);

        // T6: reset while a blocked packet waits in DELIVER.
        @(negedge clk_i);
        full_i = 9'h002;
        send(3, 32'h0100_0003);
        exp_pop.push_back(9'h008);
        repeat (3) @(negedge clk_i);
        chk("t6_busy_before_rst", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_pop", 32'(pop_o), 32'h0);
        chk("t6_rst_push", 32'(push_o), 32'h0);
        chk("t6_rst_busy", 32'(busy_o), 32'h0);
        chk("t6_rst_drop_cnt", 32'(drop_cnt_o), 32'h0);
        full_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("t6_no_push_after_rst", 32'(push_o), 32'h0);
        send(5, 32'h0700_0015);
        send(0, 32'h0200_0010);
        expect_push(0, 9'h004, 32'h0200_0010);
        expect_push(5, 9'h080, 32'h0700_0015);
        wait_quiet("t6_timeout", 40);
        chk("t6_drop_cnt_final", 32'(drop_cnt_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
